song_reader: RTL and testbench
==============================

SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter SONG_BITS, default 2: song-select width (4 songs).
REQ-002 Parameter IDX_BITS, default 5: per-song note index width (32 slots).
REQ-003 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 play  input  1  high = advance through song; low = pause, hold all state.
REQ-006 song  input  SONG_BITS  selected song; sampled on every cycle.
REQ-007 note_done  input  1  one-cycle pulse from the note player: current note finished.
REQ-008 note  output  6  note code for the note player.
REQ-009 duration  output  6  duration, in 1/48 s beats, for the note player.
REQ-010 new_note  output  1  one-cycle load strobe; note/duration are valid while high.
REQ-011 song_done  output  1  one-cycle pulse when the selected song ends.

Function
REQ-012 States: IDLE, FETCH, WAIT_ROM, LOAD, WAIT_DONE, NEXT; the encoding SHALL come from the shared package.
REQ-013 ROM address = {song, idx}; ROM word = {note[5:0], duration[5:0]}; ROM read latency is exactly 1 cycle (registered output).
REQ-014 IDLE -> FETCH when play=1; otherwise stay.
REQ-015 FETCH presents the address for 1 cycle -> WAIT_ROM; WAIT_ROM captures the ROM word into note/duration registers -> LOAD.
REQ-016 LOAD asserts new_note for exactly 1 cycle -> WAIT_DONE; new_note SHALL be 0 in every other state.
REQ-017 Latency: new_note rises on the 3rd rising edge after the edge that samples play=1 in IDLE (no pause).
REQ-018 WAIT_DONE -> NEXT on note_done=1; note_done in any other state SHALL be ignored.
REQ-019 NEXT: if idx = 2^IDX_BITS-1, or the word at idx+1 has duration=0 (end marker, checked in the following FETCH/WAIT_ROM), the song ends.
REQ-020 End of song: pulse song_done for 1 cycle, clear idx to 0, return to IDLE; no new_note is issued for an end-marker word.
REQ-021 Otherwise NEXT increments idx (IDX_BITS arithmetic, no wrap past the last slot) -> FETCH.
REQ-022 play=0 in any state SHALL freeze state, idx, note, duration and suppress new_note; an entry to LOAD while paused SHALL be deferred until play=1, and the strobe is still issued exactly once.
REQ-023 A change of song (value differs from the previous cycle) SHALL clear idx to 0 and force FETCH on the next cycle, regardless of the current state, unless reset is asserted.
REQ-024 Simultaneous note_done and song change: the song change wins; no increment of the old index.
REQ-025 note and duration SHALL hold their last loaded value between loads.

Reset
REQ-026 reset=1 on a clock edge: state=IDLE, idx=0, note=0, duration=0, new_note=0, song_done=0; reset has priority over every other input.
REQ-027 Reset in mid-song SHALL abandon the current note with no song_done pulse; the first load after release is idx 0.

Structure
REQ-028 The shared package SHALL hold: the state enum, NOTE_W=6, DUR_W=6, the ROM word field offsets, and the END_DURATION=0 constant.
REQ-029 A single submodule song_rom (synchronous read, address SONG_BITS+IDX_BITS, 12-bit data) SHALL be instantiated; all control stays in song_reader.
REQ-030 Expected size is 120-400 lines of RTL; no other submodules.

Verification
REQ-031 Song 0 holds words (note 10, dur 4), (12, 8), (0-dur end); reset, play=1 -> new_note 3 cycles later with note=10/duration=4; note_done -> next new_note with 12/8 3 cycles after NEXT; the next note_done -> song_done pulse, no third new_note.
REQ-032 Song with all 32 slots non-zero -> 32 new_note pulses, then song_done after the 32nd note_done, idx back to 0.
REQ-033 play dropped on the cycle before LOAD for 10 cycles -> new_note absent for the whole pause, then exactly one pulse after play returns.
REQ-034 In WAIT_DONE at idx 5, song changed 0->2 on the same cycle as note_done -> next new_note carries song 2, idx 0 contents.
REQ-035 reset asserted in WAIT_DONE at idx 7 -> all outputs 0 next cycle, no song_done; after release play=1 -> first load is idx 0.
REQ-036 note_done pulsed in IDLE and FETCH -> no state change and no idx change.

Source files
------------

// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader.
//   - NOTE_W / DUR_W : widths of the note code and duration fields
//   - ROM word layout: {note[NOTE_W-1:0], duration[DUR_W-1:0]}
//   - END_DURATION   : a word with this duration marks the end of a song
//   - state_e        : sequencer state encoding
package song_reader_pkg;

    localparam int unsigned NOTE_W   = 6;
    localparam int unsigned DUR_W    = 6;
    localparam int unsigned WORD_W   = NOTE_W + DUR_W;

    // Field offsets inside a ROM word.
    localparam int unsigned DUR_LSB  = 0;
    localparam int unsigned NOTE_LSB = DUR_W;

    localparam logic [DUR_W-1:0] END_DURATION = '0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_ROM  = 3'd2,
        LOAD      = 3'd3,
        WAIT_DONE = 3'd4,
        NEXT      = 3'd5
    } state_e;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[NOTE_LSB +: NOTE_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_LSB +: DUR_W];
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(input logic [NOTE_W-1:0] n,
                                                    input logic [DUR_W-1:0]  d);
        logic [WORD_W-1:0] w;
        w = '0;
        w[NOTE_LSB +: NOTE_W] = n;
        w[DUR_LSB +: DUR_W]   = d;
        return w;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Song ROM with a registered (1-cycle latency) read port.
//   clk_i  : clock
//   addr_i : {song, idx}
//   data_o : {note, duration} word for the address presented on the previous edge
// Contents:
//   song 0 : (10,4) (12,8) then end marker
//   song 1 : 32 notes, note = 20+idx, duration = idx+1 (no end marker)
//   song 2 : 8 notes, note = 40+idx, duration = 3+2*idx, then end marker
//   song 3 : 4 notes, note = 60-idx, duration = 5, then end marker
module song_rom
    import song_reader_pkg::*;
#(
    parameter int unsigned SONG_BITS = 2,
    parameter int unsigned IDX_BITS  = 5
) (
    input  logic                          clk_i,
    input  logic [SONG_BITS+IDX_BITS-1:0] addr_i,
    output logic [WORD_W-1:0]             data_o
);

    logic [WORD_W-1:0] data_q;

    function automatic logic [WORD_W-1:0] rom_word(input logic [SONG_BITS+IDX_BITS-1:0] addr);
        int unsigned       s;
        int unsigned       i;
        logic [NOTE_W-1:0] n;
        logic [DUR_W-1:0]  d;
        s = 32'(addr[IDX_BITS +: SONG_BITS]);
        i = 32'(addr[IDX_BITS-1:0]);
        n = '0;
        d = '0;
        case (s)
            0: begin
                if (i == 0) begin
                    n = NOTE_W'(10);
                    d = DUR_W'(4);
                end else if (i == 1) begin
                    n = NOTE_W'(12);
                    d = DUR_W'(8);
                end
            end
            1: begin
                n = NOTE_W'(20 + i);
                d = DUR_W'(i + 1);
            end
            2: begin
                if (i < 8) begin
                    n = NOTE_W'(40 + i);
                    d = DUR_W'(3 + 2 * i);
                end
            end
            3: begin
                if (i < 4) begin
                    n = NOTE_W'(60 - i);
                    d = DUR_W'(5);
                end
            end
            default: begin
                n = '0;
                d = '0;
            end
        endcase
        return pack_word(n, d);
    endfunction

    always_ff @(posedge clk_i) begin
        data_q <= rom_word(addr_i);
    end

    assign data_o = data_q;

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the notes of the selected song in the song ROM and hands
// them one at a time to the note player.
//   clk        : clock, all logic on the rising edge
//   reset      : synchronous active-high reset
//   play       : 1 = advance, 0 = pause (all state held, strobe suppressed)
//   song       : selected song; any change restarts at index 0
//   note_done  : pulse from the note player, current note finished
//   note       : note code of the last loaded word
//   duration   : duration of the last loaded word (1/48 s beats)
//   new_note   : one-cycle load strobe for note/duration
//   song_done  : one-cycle pulse when the selected song ends
module song_reader
    import song_reader_pkg::*;
#(
    parameter int unsigned SONG_BITS = 2,
    parameter int unsigned IDX_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play,
    input  logic [SONG_BITS-1:0] song,
    input  logic                 note_done,
    output logic [NOTE_W-1:0]    note,
    output logic [DUR_W-1:0]     duration,
    output logic                 new_note,
    output logic                 song_done
);

    localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

    state_e                state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [NOTE_W-1:0]     note_q, note_d;
    logic [DUR_W-1:0]      dur_q, dur_d;
    logic                  song_done_q, song_done_d;
    logic [SONG_BITS-1:0]  song_prev_q;
    logic                  song_changed;

    logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
    logic [WORD_W-1:0]             rom_data;
    logic [NOTE_W-1:0]             rom_note;
    logic [DUR_W-1:0]              rom_dur;

    assign rom_addr = {song, idx_q};
    assign rom_note = word_note(rom_data);
    assign rom_dur  = word_dur(rom_data);

    song_rom #(
        .SONG_BITS (SONG_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_rom (
        .clk_i  (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    assign song_changed = (song != song_prev_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        note_d      = note_q;
        dur_d       = dur_q;
        song_done_d = 1'b0;
        new_note    = 1'b0;

        // A song change takes precedence over pause and over note_done: the
        // index restarts and the sequencer refetches (it will then sit in
        // FETCH if play is low).
        if (song_changed) begin
            state_d = FETCH;
            idx_d   = '0;
        end else if (play) begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    state_d = WAIT_ROM;
                end
                WAIT_ROM: begin
                    // End marker: finish the song without loading the word.
                    if (rom_dur == END_DURATION) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        song_done_d = 1'b1;
                    end else begin
                        note_d  = rom_note;
                        dur_d   = rom_dur;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    // Strobe only while play is high, so a pause in LOAD
                    // defers the single strobe until play returns.
                    new_note = 1'b1;
                    state_d  = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (note_done) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        song_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_BITS'(1);
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            song_done_q <= 1'b0;
            // Track the current selection so leaving reset is not seen as a change.
            song_prev_q <= song;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            song_done_q <= song_done_d;
            song_prev_q <= song;
        end
    end

    assign note      = note_q;
    assign duration  = dur_q;
    assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
module tb_song_reader;

    logic       clk;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int errors = 0;
    int checks = 0;

    song_reader #(
        .SONG_BITS (2),
        .IDX_BITS  (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference song table: number of notes and each note's (note, duration).
    function automatic int song_len(input int s);
        case (s)
            0:       return 2;
            1:       return 32;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_note(input int s, input int i);
        case (s)
            0:       return (i == 0) ? 10 : 12;
            1:       return 20 + i;
            2:       return 40 + i;
            default: return 60 - i;
        endcase
    endfunction

    function automatic int exp_dur(input int s, input int i);
        case (s)
            0:       return (i == 0) ? 4 : 8;
            1:       return i + 1;
            2:       return 3 + 2 * i;
            default: return 5;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] s);
        song      = s;
        play      = 1'b0;
        note_done = 1'b0;
        reset     = 1'b1;
        tick;
        tick;
        reset     = 1'b0;
    endtask

    // Advance until new_note is seen; cyc = edges waited, -1 on timeout.
    task automatic wait_nn(input int limit, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < limit) begin
            tick;
            cyc++;
            if (new_note === 1'b1) done = 1'b1;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset;
        song      = 2'd0;
        play      = 1'b1;
        note_done = 1'b1;
        reset     = 1'b1;
        tick;
        tick;
        checks++; if (note !== 6'd0) begin errors++; $display("FAIL reset_note: got %0d want 0", note); end
        checks++; if (duration !== 6'd0) begin errors++; $display("FAIL reset_duration: got %0d want 0", duration); end
        checks++; if (new_note !== 1'b0) begin errors++; $display("FAIL reset_new_note: got %0b want 0", new_note); end
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL reset_song_done: got %0b want 0", song_done); end
        reset     = 1'b0;
        play      = 1'b0;
        note_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if (new_note !== 1'b0 || song_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: got new_note=%0b song_done=%0b want 0/0", new_note, song_done);
            end
        end
    endtask

    task automatic test_song0;
        int delay;
        do_reset(2'd0);
        play = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++;
            if (new_note !== (k == 3)) begin errors++; $display("FAIL s0_first_latency k=%0d: got %0b want %0b", k, new_note, (k == 3)); end
        end
        checks++; if (note !== 6'd10) begin errors++; $display("FAIL s0_note0: got %0d want 10", note); end
        checks++; if (duration !== 6'd4) begin errors++; $display("FAIL s0_dur0: got %0d want 4", duration); end
        delay = $urandom_range(1, 6);
        for (int j = 0; j < delay; j++) begin
            tick;
            checks++;
            if (new_note !== 1'b0 || note !== 6'd10 || duration !== 6'd4) begin
                errors++;
                $display("FAIL s0_hold: got nn=%0b note=%0d dur=%0d want 0/10/4", new_note, note, duration);
            end
        end
        note_done = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            note_done = 1'b0;
            checks++;
            if (new_note !== (k == 4)) begin errors++; $display("FAIL s0_second_latency k=%0d: got %0b want %0b", k, new_note, (k == 4)); end
        end
        checks++; if (note !== 6'd12) begin errors++; $display("FAIL s0_note1: got %0d want 12", note); end
        checks++; if (duration !== 6'd8) begin errors++; $display("FAIL s0_dur1: got %0d want 8", duration); end
        tick;
        note_done = 1'b1;
        // End marker: song_done on the 4th edge, then replay from index 0.
        for (int k = 1; k <= 7; k++) begin
            tick;
            note_done = 1'b0;
            checks++;
            if (new_note !== (k == 7) || song_done !== (k == 4)) begin
                errors++;
                $display("FAIL s0_end k=%0d: got nn=%0b sd=%0b want %0b/%0b", k, new_note, song_done, (k == 7), (k == 4));
            end
            if (k == 5) begin
                checks++;
                if (note !== 6'd12 || duration !== 6'd8) begin
                    errors++;
                    $display("FAIL s0_end_hold: got %0d/%0d want 12/8", note, duration);
                end
            end
        end
        checks++;
        if (note !== 6'd10 || duration !== 6'd4) begin
            errors++;
            $display("FAIL s0_replay: got %0d/%0d want 10/4", note, duration);
        end
        play = 1'b0;
    endtask

    task automatic test_full_song;
        int cyc;
        bit seen;
        do_reset(2'd1);
        play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wait_nn(10, cyc);
            checks++;
            if (cyc != 3) begin errors++; $display("FAIL full_latency idx=%0d: got %0d want 3", i, cyc); end
            checks++;
            if (note !== exp_note(1, i) || duration !== exp_dur(1, i)) begin
                errors++;
                $display("FAIL full_word idx=%0d: got %0d/%0d want %0d/%0d", i, note, duration, exp_note(1, i), exp_dur(1, i));
            end
            tick;
            repeat ($urandom_range(0, 3)) tick;
            note_done = 1'b1;
            tick;
            note_done = 1'b0;
        end
        seen = 1'b0;
        for (int k = 1; k <= 4 && !seen; k++) begin
            tick;
            checks++;
            if (new_note !== 1'b0) begin errors++; $display("FAIL full_extra_note k=%0d: got %0b want 0", k, new_note); end
            if (song_done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (k != 1) begin errors++; $display("FAIL full_done_latency: got %0d want 1", k); end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL full_song_done: got 0 want 1"); end
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++;
            if (new_note !== (k == 3)) begin errors++; $display("FAIL full_restart k=%0d: got %0b want %0b", k, new_note, (k == 3)); end
        end
        checks++;
        if (note !== 6'd20 || duration !== 6'd1) begin
            errors++;
            $display("FAIL full_restart_word: got %0d/%0d want 20/1", note, duration);
        end
        play = 1'b0;
    endtask

    task automatic test_pause;
        do_reset(2'd3);
        play = 1'b1;
        tick;
        tick;
        checks++;
        if (new_note !== 1'b0) begin errors++; $display("FAIL pause_pre: got %0b want 0", new_note); end
        play = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick;
            checks++;
            if (new_note !== 1'b0) begin errors++; $display("FAIL pause_hold k=%0d: got %0b want 0", k, new_note); end
        end
        play = 1'b1;
        tick;
        checks++;
        if (new_note !== 1'b1 || note !== 6'd60 || duration !== 6'd5) begin
            errors++;
            $display("FAIL pause_resume: got nn=%0b %0d/%0d want 1 60/5", new_note, note, duration);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if (new_note !== 1'b0) begin errors++; $display("FAIL pause_single k=%0d: got %0b want 0", k, new_note); end
        end
        note_done = 1'b1;
        tick;
        note_done = 1'b0;
        tick;
        tick;
        tick;
        checks++;
        if (new_note !== 1'b1 || note !== 6'd59) begin
            errors++;
            $display("FAIL pause_load_entry: got nn=%0b note=%0d want 1 59", new_note, note);
        end
        // Pause while sitting in LOAD: strobe withdrawn, then issued once.
        play = 1'b0;
        #1;
        checks++;
        if (new_note !== 1'b0) begin errors++; $display("FAIL pause_in_load: got %0b want 0", new_note); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (new_note !== 1'b0) begin errors++; $display("FAIL pause_in_load_hold k=%0d: got %0b want 0", k, new_note); end
        end
        play = 1'b1;
        #1;
        checks++;
        if (new_note !== 1'b1) begin errors++; $display("FAIL pause_load_resume: got %0b want 1", new_note); end
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if (new_note !== 1'b0) begin errors++; $display("FAIL pause_load_single k=%0d: got %0b want 0", k, new_note); end
        end
        play = 1'b0;
    endtask

    task automatic test_song_change;
        int cyc;
        do_reset(2'd1);
        play = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            wait_nn(10, cyc);
            checks++;
            if (cyc < 0 || note !== exp_note(1, i) || duration !== exp_dur(1, i)) begin
                errors++;
                $display("FAIL chg_word idx=%0d: got %0d/%0d want %0d/%0d", i, note, duration, exp_note(1, i), exp_dur(1, i));
            end
            tick;
            if (i < 5) begin
                note_done = 1'b1;
                tick;
                note_done = 1'b0;
            end
        end
        song      = 2'd2;
        note_done = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            note_done = 1'b0;
            checks++;
            if (new_note !== (k == 3) || song_done !== 1'b0) begin
                errors++;
                $display("FAIL chg_latency k=%0d: got nn=%0b sd=%0b want %0b/0", k, new_note, song_done, (k == 3));
            end
        end
        checks++;
        if (note !== exp_note(2, 0) || duration !== exp_dur(2, 0)) begin
            errors++;
            $display("FAIL chg_word_new: got %0d/%0d want %0d/%0d", note, duration, exp_note(2, 0), exp_dur(2, 0));
        end
        play = 1'b0;
    endtask

    task automatic test_reset_mid;
        int cyc;
        do_reset(2'd1);
        play = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            wait_nn(10, cyc);
            if (i == 7) begin
                checks++;
                if (cyc < 0 || note !== exp_note(1, 7)) begin
                    errors++;
                    $display("FAIL rmid_idx7: got %0d want %0d", note, exp_note(1, 7));
                end
            end
            tick;
            if (i < 7) begin
                note_done = 1'b1;
                tick;
                note_done = 1'b0;
            end
        end
        reset = 1'b1;
        play  = 1'b0;
        tick;
        reset = 1'b0;
        checks++;
        if (note !== 6'd0 || duration !== 6'd0 || new_note !== 1'b0 || song_done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_outputs: got %0d/%0d nn=%0b sd=%0b want 0/0 0 0", note, duration, new_note, song_done);
        end
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++;
            if (song_done !== 1'b0 || new_note !== 1'b0) begin
                errors++;
                $display("FAIL rmid_quiet k=%0d: got sd=%0b nn=%0b want 0/0", k, song_done, new_note);
            end
        end
        play = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++;
            if (new_note !== (k == 3)) begin errors++; $display("FAIL rmid_restart k=%0d: got %0b want %0b", k, new_note, (k == 3)); end
        end
        checks++;
        if (note !== 6'd20 || duration !== 6'd1) begin
            errors++;
            $display("FAIL rmid_first_word: got %0d/%0d want 20/1", note, duration);
        end
        play = 1'b0;
    endtask

    task automatic test_ignored_note_done;
        do_reset(2'd2);
        note_done = 1'b1;
        tick;
        note_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (new_note !== 1'b0 || song_done !== 1'b0) begin
                errors++;
                $display("FAIL ign_idle k=%0d: got nn=%0b sd=%0b want 0/0", k, new_note, song_done);
            end
        end
        play = 1'b1;
        tick;
        note_done = 1'b1;
        tick;
        note_done = 1'b0;
        tick;
        checks++;
        if (new_note !== 1'b1 || note !== 6'd40 || duration !== 6'd3) begin
            errors++;
            $display("FAIL ign_fetch_load: got nn=%0b %0d/%0d want 1 40/3", new_note, note, duration);
        end
        // No note_done since the load: the reader must still be waiting.
        for (int k = 0; k < 6; k++) begin
            tick;
            checks++;
            if (new_note !== 1'b0 || song_done !== 1'b0 || note !== 6'd40) begin
                errors++;
                $display("FAIL ign_wait k=%0d: got nn=%0b sd=%0b note=%0d want 0/0/40", k, new_note, song_done, note);
            end
        end
        play = 1'b0;
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            int  s;
            int  len;
            bit  seen;
            bit  early;
            int  extra;
            int  got_n;
            int  got_d;
            bit  abort;
            s     = $urandom_range(0, 3);
            len   = song_len(s);
            abort = 1'b0;
            do_reset(2'(s));
            for (int i = 0; i < len && !abort; i++) begin
                seen  = 1'b0;
                early = 1'b0;
                got_n = 0;
                got_d = 0;
                for (int c = 0; c < 400 && !seen; c++) begin
                    play      = ($urandom_range(0, 3) != 0);
                    note_done = ($urandom_range(0, 4) == 0);
                    #1;
                    if (song_done === 1'b1) early = 1'b1;
                    if (new_note === 1'b1) begin
                        seen  = 1'b1;
                        got_n = int'(note);
                        got_d = int'(duration);
                    end
                    tick;
                end
                note_done = 1'b0;
                checks++;
                if (!seen || early) begin
                    errors++;
                    $display("FAIL rand_load song=%0d idx=%0d: got seen=%0b early_done=%0b want 1/0", s, i, seen, early);
                    abort = 1'b1;
                end
                if (!abort) begin
                    checks++;
                    if (got_n != exp_note(s, i) || got_d != exp_dur(s, i)) begin
                        errors++;
                        $display("FAIL rand_word song=%0d idx=%0d: got %0d/%0d want %0d/%0d", s, i, got_n, got_d, exp_note(s, i), exp_dur(s, i));
                    end
                    repeat ($urandom_range(0, 4)) begin
                        play = ($urandom_range(0, 1) != 0);
                        tick;
                    end
                    play      = 1'b1;
                    note_done = 1'b1;
                    tick;
                    note_done = 1'b0;
                end
            end
            if (!abort) begin
                seen  = 1'b0;
                extra = 0;
                for (int c = 0; c < 400 && !seen; c++) begin
                    play      = ($urandom_range(0, 3) != 0);
                    note_done = ($urandom_range(0, 4) == 0);
                    #1;
                    if (new_note === 1'b1) extra++;
                    if (song_done === 1'b1) seen = 1'b1;
                    tick;
                end
                note_done = 1'b0;
                checks++;
                if (!seen || extra != 0) begin
                    errors++;
                    $display("FAIL rand_end song=%0d: got done=%0b extra_loads=%0d want 1/0", s, seen, extra);
                end
            end
            play = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        play      = 1'b0;
        note_done = 1'b0;
        song      = 2'd0;
        test_reset;
        test_song0;
        test_full_song;
        test_pause;
        test_song_change;
        test_reset_mid;
        test_ignored_note_done;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
